// File: rtl/histogram_run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hist_ctrl_pkg
// Purpose  : Shared types and default widths for the histogram run controller.
// Revision : 1.0  initial release
// ============================================================================
package hist_ctrl_pkg;

  localparam int c_BIN_W = 7;   // histogram address width (2^7 bins)
  localparam int c_CNT_W = 16;  // bin count width, equal to memory data width
  localparam int c_SMP_W = 16;  // sample-count width

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_ADDR  = 3'd3,
    S_CAPT  = 3'd4,
    S_HOLD  = 3'd5,
    S_FIN   = 3'd6
  } hist_ctrl_state_t;

  // Index of the final histogram bin for a given address width.
  function automatic int unsigned last_bin(input int unsigned bin_w);
    return (32'd1 << bin_w) - 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/histogram_run_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : histogram_run_ctrl_if
// Purpose  : Control, datapath and readout-stream signals of the run controller.
// Revision : 1.0  initial release
// ============================================================================
interface histogram_run_ctrl_if #(
  parameter int BIN_W = 7,
  parameter int CNT_W = 16,
  parameter int SMP_W = 16
) ();

  logic             start;
  logic             abort;
  logic [SMP_W-1:0] n_samples;
  logic             busy;
  logic             done;
  logic             dp_rst;
  logic             dp_ena;
  logic [BIN_W-1:0] rd_addr;
  logic [CNT_W-1:0] rd_data;
  logic             out_valid;
  logic             out_ready;
  logic [BIN_W-1:0] out_bin;
  logic [CNT_W-1:0] out_count;

  // Controller side
  modport master (
    input  start, abort, n_samples, rd_data, out_ready,
    output busy, done, dp_rst, dp_ena, rd_addr, out_valid, out_bin, out_count
  );

  // Requester / datapath / consumer side
  modport slave (
    output start, abort, n_samples, rd_data, out_ready,
    input  busy, done, dp_rst, dp_ena, rd_addr, out_valid, out_bin, out_count
  );

endinterface
`default_nettype wire

// File: rtl/histogram_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : histogram_run_ctrl
// Purpose  : Clears the histogram, runs the LFSR/histogram pair for a
//            programmed number of samples, then streams every bin out.
// Revision : 1.0  initial release
// ============================================================================
module histogram_run_ctrl
  import hist_ctrl_pkg::*;
#(
  parameter int BIN_W = c_BIN_W,
  parameter int CNT_W = c_CNT_W,
  parameter int SMP_W = c_SMP_W
) (
  input wire logic              CLK,
  input wire logic              RST,
  histogram_run_ctrl_if.master  bus
);

  localparam logic [BIN_W-1:0] c_LAST_BIN = BIN_W'(last_bin(BIN_W));

  hist_ctrl_state_t r_state;
  hist_ctrl_state_t w_state_nxt;

  logic [SMP_W-1:0] r_n;          // latched sample target
  logic [SMP_W-1:0] r_smp_cnt;    // enabled cycles issued so far
  logic [BIN_W-1:0] r_bin;        // bin counter, also drives rd_addr
  logic             r_busy;
  logic             r_done;
  logic             r_dp_rst;
  logic             r_dp_ena;
  logic             r_out_valid;
  logic [BIN_W-1:0] r_out_bin;
  logic [CNT_W-1:0] r_out_count;

  // Next-state decode; abort overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_CLEAR;
      S_CLEAR: w_state_nxt = (r_n == '0) ? S_ADDR : S_RUN;
      S_RUN:   if (r_smp_cnt == (r_n - SMP_W'(1))) w_state_nxt = S_ADDR;
      S_ADDR:  w_state_nxt = S_CAPT;
      S_CAPT:  w_state_nxt = S_HOLD;
      S_HOLD:  if (bus.out_ready) w_state_nxt = (r_bin == c_LAST_BIN) ? S_FIN : S_ADDR;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.abort) w_state_nxt = S_IDLE;
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Counters and registered outputs; status flags are decoded from the
  // next state so they line up with the state they describe.
  always_ff @(posedge CLK) begin
    if (RST || bus.abort) begin
      r_n         <= '0;
      r_smp_cnt   <= '0;
      r_bin       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dp_rst    <= 1'b0;
      r_dp_ena    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_bin   <= '0;
      r_out_count <= '0;
    end else begin
      r_busy   <= (w_state_nxt != S_IDLE);
      r_done   <= (w_state_nxt == S_FIN);
      r_dp_rst <= (w_state_nxt == S_CLEAR);
      r_dp_ena <= (w_state_nxt == S_RUN);

      case (r_state)
        S_IDLE: if (bus.start) r_n <= bus.n_samples;
        S_CLEAR: begin
          r_smp_cnt <= '0;
          r_bin     <= '0;
        end
        S_RUN:   r_smp_cnt <= r_smp_cnt + SMP_W'(1);
        S_CAPT: begin
          r_out_count <= bus.rd_data;
          r_out_bin   <= r_bin;
          r_out_valid <= 1'b1;
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            if (r_bin != c_LAST_BIN) r_bin <= r_bin + BIN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.dp_rst    = r_dp_rst;
  assign bus.dp_ena    = r_dp_ena;
  assign bus.rd_addr   = r_bin;
  assign bus.out_valid = r_out_valid;
  assign bus.out_bin   = r_out_bin;
  assign bus.out_count = r_out_count;

endmodule
`default_nettype wire
